// File: rtl/wiscsc15_fetch_queue.sv
// wiscsc15_fetch_queue
// Prefetching instruction fetch front end for the WISC-SC15 core. It issues
// handshaked requests to a variable-latency instruction memory and keeps up to
// DEPTH fetched {pc, instr} pairs in a circular buffer. The oldest pair is
// presented to decode with a valid/ready handshake. Redirects from execute
// flush the buffer and restart fetch. Prefetch stops after a HLT word.
module wiscsc15_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    output logic                     mem_req,
    output logic [15:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [15:0]              mem_rdata,
    output logic                     inst_valid,
    output logic [15:0]              inst,
    output logic [15:0]              inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [3:0] HLT_OPCODE = 4'hF;

    // IDLE: no request outstanding.
    // REQ: request outstanding whose data will be pushed.
    // FLUSH: request outstanding whose data belongs to a redirected-away path.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     addr_nxt;
    logic [15:0]     fpc;
    logic [15:0]     fpc_nxt;
    logic            hlt_seen;
    logic            hlt_nxt;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_after;

    logic [15:0]     pc_store    [DEPTH];
    logic [15:0]     instr_store [DEPTH];

    logic            ack;
    logic            push;
    logic            pop;
    logic            push_hlt;

    // A completed request only counts while a request is actually open.
    assign ack      = mem_req & mem_ack;

    // A redirect drops any push or pop that coincides with it.
    assign push     = (state == REQ) & ack & ~redirect;
    assign pop      = inst_valid & inst_ready & ~redirect;
    assign push_hlt = (mem_rdata[15:12] == HLT_OPCODE);

    // Head outputs come straight from registered state, zeroed when empty.
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? instr_store[rd_ptr] : 16'h0000;
    assign inst_pc    = inst_valid ? pc_store[rd_ptr]    : 16'h0000;

    // Occupancy after this cycle's push and pop, used to decide whether the
    // next request can be started back to back without overrunning the queue.
    always_comb begin
        count_after = count;
        if (push && !pop) begin
            count_after = count + CW'(1);
        end else if (!push && pop) begin
            count_after = count - CW'(1);
        end
    end

    // Fetch control: next state, next request address, fetch PC and halt flag.
    // A request is only launched when an entry is guaranteed free on return.
    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_addr;
        fpc_nxt   = fpc;
        hlt_nxt   = hlt_seen;
        if (redirect) begin
            fpc_nxt = redirect_pc;
            hlt_nxt = 1'b0;
            case (state)
                IDLE: begin
                    state_nxt = REQ;
                    addr_nxt  = redirect_pc;
                end
                REQ, FLUSH: begin
                    if (ack) begin
                        state_nxt = REQ;
                        addr_nxt  = redirect_pc;
                    end else begin
                        state_nxt = FLUSH;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count < FULL && !hlt_seen) begin
                        state_nxt = REQ;
                        addr_nxt  = fpc;
                    end
                end
                REQ: begin
                    if (ack) begin
                        fpc_nxt = mem_addr + 16'd1;
                        if (push_hlt) begin
                            hlt_nxt = 1'b1;
                        end
                        if (count_after < FULL && !push_hlt) begin
                            state_nxt = REQ;
                            addr_nxt  = mem_addr + 16'd1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (ack) begin
                        if (!hlt_seen && count < FULL) begin
                            state_nxt = REQ;
                            addr_nxt  = fpc;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Fetch state, request output and fetch PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= 16'h0000;
            fpc      <= 16'h0000;
            hlt_seen <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_req  <= (state_nxt != IDLE);
            mem_addr <= addr_nxt;
            fpc      <= fpc_nxt;
            hlt_seen <= hlt_nxt;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_after;
        end
    end

    // Entry storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_store[wr_ptr]    <= mem_addr;
            instr_store[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: doc/wiscsc15_fetch_queue.md
# wiscsc15_fetch_queue

Instruction fetch front end for the WISC-SC15 core: sits directly upstream of the decode/control stage and replaces the ideal single-cycle instruction memory with a prefetching, handshaked fetch path to a variable-latency instruction memory. It holds up to DEPTH fetched instructions with their PCs, presents the oldest one to decode with a valid/ready handshake, and flushes on control-flow redirects (branch, call, return) from execute. It stops prefetching past a HLT instruction.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-low.
- redirect  in  1  one-cycle pulse; flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address; valid when redirect=1.
- mem_req  out  1  fetch request to instruction memory; registered.
- mem_addr  out  16  word address of the request; registered; stable while mem_req=1.
- mem_ack  in  1  memory completes the current request this cycle; counted only when mem_req=1.
- mem_rdata  in  16  instruction word; valid when mem_ack=1.
- inst_valid  out  1  queue head is valid.
- inst  out  16  queue-head instruction; 16'h0000 when inst_valid=0.
- inst_pc  out  16  PC of the queue head; 16'h0000 when inst_valid=0.
- inst_ready  in  1  decode accepts the head this cycle; a pop occurs when inst_valid & inst_ready.
- count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries, each {pc[15:0], instr[15:0]}, with read and write pointers that wrap modulo DEPTH. The counter `count` tracks occupancy.
- Fetch PC register `fpc` holds the address of the next instruction to request. Reset value 16'h0000. It increments by 1 per accepted (non-discarded) ack and wraps from 16'hFFFF to 16'h0000.
- Halted flag `hlt_seen`: set when a pushed instruction has instr[15:12]==4'hF. While set, no new request is started. Cleared by redirect or reset.
- At most one request is outstanding. Once mem_req rises, it stays high with a constant mem_addr until the cycle in which mem_ack=1.
- States:
  - IDLE: mem_req=0. Move to REQ with mem_addr<=fpc when count<DEPTH and hlt_seen=0.
  - REQ: mem_req=1. On mem_ack:
    - Push {mem_addr, mem_rdata} and set fpc<=mem_addr+1.
    - Stay in REQ with mem_addr<=mem_addr+1 if, after this cycle's push and pop, count<DEPTH and the pushed word is not HLT. Otherwise go to IDLE.
  - FLUSH: mem_req=1 for a stale address. On mem_ack, discard the data (no push) and go to REQ with mem_addr<=fpc if hlt_seen=0 and count<DEPTH, else to IDLE.
- Space reservation: a request starts only if an entry will be free when it returns, so a push never meets a full queue.
- Redirect has priority over every other event in its cycle:
  - count<=0; both pointers reset to 0.
  - Any simultaneous push or pop is dropped.
  - hlt_seen<=0 and fpc<=redirect_pc.
  - From IDLE: go to REQ with mem_addr<=redirect_pc.
  - From REQ with mem_ack=1 in the same cycle: the ack completes the old request, its data is dropped, and the next state is REQ with mem_addr<=redirect_pc.
  - From REQ with mem_ack=0: go to FLUSH, keeping mem_addr unchanged.
  - From FLUSH: stay in FLUSH, or if mem_ack=1, go to REQ at redirect_pc.
- Simultaneous push and pop leaves count unchanged. A pop on an empty queue is impossible because it requires inst_valid.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, mem_req=0, mem_addr=0, fpc=0, count=0, pointers=0, hlt_seen=0, inst_valid=0, inst=0, inst_pc=0. Reset asserted mid-request abandons the request; memory is reset together with this block.
- First cycle after reset release: IDLE. mem_req=1, addr 0 in cycle 1.
- Latency from ack to decode: data acked at edge N is at the head with inst_valid=1 in cycle N+1 if the queue was empty. There is no combinational bypass from mem_rdata.
- With a zero-wait memory (mem_ack tied high), steady-state throughput is 1 instruction/cycle while decode keeps inst_ready=1.
- Redirect to first new instruction: redirect at edge R. mem_req at redirect_pc in cycle R+1 (no stale request). inst_valid in cycle R+2 with zero-wait memory.
- inst_valid, inst, inst_pc and count are functions of registered state only.

## Test plan
- Reset release, mem_ack tied 1, inst_ready tied 1, memory word = 16'h1000+addr: inst_pc sequence 0,1,2,... on consecutive cycles from cycle 2, and inst = 16'h1000+inst_pc.
- inst_ready=0, DEPTH=4: exactly 4 acks accepted, then mem_req=0 and count=4. Raising inst_ready for 1 cycle causes a pop, count=3, and a new request at addr 4.
- Memory ack latency 3 cycles, redirect to 16'h0040 in the 2nd wait cycle of a request to addr 5: addr 5 stays held until its ack, its data is discarded, the next mem_addr is 16'h0040, and the head shows inst_pc 16'h0040.
- HLT (16'hF000) at addr 2, inst_ready=0: addrs 0-2 are pushed, no request for addr 3, and the block stays idle for 20 cycles. Redirect to 16'h0010 resumes fetching.
- Redirect, pop and ack in the same cycle with count=2: next cycle count=0, inst_valid=0, and the acked data is not visible.
- rst pulled low while mem_req=1 and count=3: all outputs are 0 immediately, without waiting for a clock edge, and fetch restarts at addr 0 after release.
